// File: rtl/mnist_infer_ctrl.sv
// Sequencer and result stage for the two-layer MNIST datapath: issues one
// datapath pulse per request, captures the class scores, finds their argmax serially and holds the result until acknowledged.
module mnist_infer_ctrl #(
    parameter int unsigned PIPE_LAT = 4,
    parameter int unsigned DW       = 32,
    parameter int unsigned NCLS     = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               ready,
    output logic               layer_valid,
    input  logic [NCLS*DW-1:0] scores,
    output logic               busy,
    output logic               done,
    output logic [3:0]         class_idx,
    output logic [DW-1:0]      class_score,
    input  logic               res_ack,
    output logic [15:0]        inf_count
);

    localparam int unsigned PW  = (NCLS > 2) ? $clog2(NCLS) : 1;
    localparam int unsigned WCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SCAN  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [WCW-1:0]       r_wcnt;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_best_idx;
    logic signed [DW-1:0] r_best;
    logic signed [DW-1:0] r_bank [NCLS];
    logic signed [DW-1:0] w_cand;
    logic                 w_win;
    logic                 w_wait_last;
    logic                 w_scan_last;

    logic                 r_ready;
    logic                 r_layer_valid;
    logic                 r_busy;
    logic                 r_done;
    logic [3:0]           r_class_idx;
    logic [DW-1:0]        r_class_score;
    logic [15:0]          r_inf_count;

    assign w_wait_last = (r_wcnt == WCW'(PIPE_LAT - 1));
    assign w_scan_last = (r_ptr == PW'(NCLS - 1));
    assign w_cand      = r_bank[r_ptr];
    // Strict greater-than: ties keep the lower index.
    assign w_win       = (w_cand > r_best);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_wait_last) w_next = S_SCAN;
            S_SCAN:  if (w_scan_last) w_next = S_HOLD;
            S_HOLD:  if (res_ack) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready       <= 1'b1;
            r_layer_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_ready       <= (w_next == S_IDLE);
            r_layer_valid <= (w_next == S_ISSUE);
            r_busy        <= (w_next == S_ISSUE) || (w_next == S_WAIT) || (w_next == S_SCAN);
            r_done        <= (w_next == S_HOLD);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt        <= '0;
            r_ptr         <= '0;
            r_best_idx    <= '0;
            r_best        <= '0;
            r_class_idx   <= '0;
            r_class_score <= '0;
            r_inf_count   <= '0;
            for (int i = 0; i < int'(NCLS); i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            case (r_state)
                S_ISSUE: r_wcnt <= '0;
                S_WAIT: begin
                    r_wcnt <= r_wcnt + WCW'(1);
                    if (w_wait_last) begin
                        for (int i = 0; i < int'(NCLS); i++) begin
                            r_bank[i] <= scores[i*DW +: DW];
                        end
                        r_best     <= scores[DW-1:0];
                        r_best_idx <= '0;
                        r_ptr      <= PW'(1);
                    end
                end
                S_SCAN: begin
                    if (w_win) begin
                        r_best     <= w_cand;
                        r_best_idx <= r_ptr;
                    end
                    r_ptr <= r_ptr + PW'(1);
                    if (w_scan_last) begin
                        r_class_idx   <= 4'(w_win ? r_ptr : r_best_idx);
                        r_class_score <= w_win ? w_cand : r_best;
                    end
                end
                S_HOLD: if (res_ack) r_inf_count <= r_inf_count + 16'd1;
                default: ;
            endcase
        end
    end

    assign ready       = r_ready;
    assign layer_valid = r_layer_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign class_idx   = r_class_idx;
    assign class_score = r_class_score;
    assign inf_count   = r_inf_count;

endmodule

// File: tb/tb_mnist_infer_ctrl.sv
// Scoreboard bench for mnist_infer_ctrl: expected argmax results are queued
// at request time and compared by an independent monitor while done is high.
module tb_mnist_infer_ctrl;

    localparam int LAT = 4;
    localparam int NC  = 10;
    localparam int DW  = 32;

    typedef logic signed [DW-1:0] sarr_t [NC];
    typedef struct {
        logic [3:0]    idx;
        logic [DW-1:0] sc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              res_ack;
    logic [NC*DW-1:0]  scores;
    logic              ready;
    logic              layer_valid;
    logic              busy;
    logic              done;
    logic [3:0]        class_idx;
    logic [DW-1:0]     class_score;
    logic [15:0]       inf_count;

    exp_t sb_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   model_cnt = 0;

    mnist_infer_ctrl #(.PIPE_LAT(LAT), .DW(DW), .NCLS(NC)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .layer_valid(layer_valid), .scores(scores), .busy(busy), .done(done),
        .class_idx(class_idx), .class_score(class_score),
        .res_ack(res_ack), .inf_count(inf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Reference: largest value wins, lowest index among equals.
    function automatic exp_t model(input sarr_t sv);
        exp_t e;
        logic signed [DW-1:0] mx;
        mx = sv[0];
        foreach (sv[i]) if (sv[i] > mx) mx = sv[i];
        e.idx = 4'd0;
        for (int i = NC - 1; i >= 0; i--) if (sv[i] == mx) e.idx = 4'(i);
        e.sc = mx;
        return e;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 64'(ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_lv"}, 64'(layer_valid), 64'd0);
        check({tag, "_idx"}, 64'(class_idx), 64'd0);
        check({tag, "_score"}, 64'(class_score), 64'd0);
        check({tag, "_count"}, 64'(inf_count), 64'd0);
    endtask

    // Monitor: pop on rising done, compare the result every cycle done is held.
    initial begin
        exp_t cur;
        logic prev;
        prev = 1'b0;
        cur.idx = '0;
        cur.sc  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (done && !prev) begin
                    if (sb_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
                    else cur = sb_q.pop_front();
                end
                if (done) begin
                    check("class_idx", 64'(class_idx), 64'(cur.idx));
                    check("class_score", 64'(class_score), 64'(cur.sc));
                end
                prev = done;
            end
        end
    end

    // Called just after a negedge; start is accepted in the first cycle ready is seen.
    task automatic run_inf(input sarr_t sv, input int ack_dly, input bit perturb, input bit ack_start);
        int   lv_n, lv_cyc, done_cyc, k;
        exp_t e;
        lv_n = 0; lv_cyc = -1; done_cyc = -1; k = 0;
        for (int i = 0; i < NC; i++) scores[i*DW +: DW] = sv[i];
        e = model(sv);
        start = 1'b1;
        while (!ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!ready) begin
            check("start_timeout", 64'd0, 64'd1);
            start = 1'b0;
            return;
        end
        sb_q.push_back(e);
        for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (layer_valid) begin
                lv_n++;
                lv_cyc = c;
            end
            if (done) done_cyc = c;
            if (perturb && c == LAT + 2) scores[9*DW +: DW] = 32'h7FFF_FFFF;
            if (perturb && c == LAT + 4) start = 1'b1;
        end
        start = 1'b0;
        check("lv_count", 64'(lv_n), 64'd1);
        check("lv_cycle", 64'(lv_cyc), 64'd1);
        check("done_cycle", 64'(done_cyc), 64'(LAT + NC + 1));
        if (done_cyc < 0) return;
        repeat (ack_dly) @(negedge clk);
        check("done_held", 64'(done), 64'd1);
        res_ack = 1'b1;
        if (ack_start) start = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        model_cnt = (model_cnt + 1) & 16'hFFFF;
        check("ready_after_ack", 64'(ready), 64'd1);
        check("done_after_ack", 64'(done), 64'd0);
        check("inf_count", 64'(inf_count), 64'(model_cnt));
        if (ack_start) begin
            check("start_with_ack_ignored", 64'(layer_valid), 64'd0);
            start = 1'b0;
        end
    endtask

    initial begin
        sarr_t sv;
        bit    seen;
        rst = 1'b1; start = 1'b0; res_ack = 1'b0; scores = '0;
        #1;
        check_reset_vals("rst_init");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (sv[i]) sv[i] = 32'h10;
        sv[3] = 32'h100;
        run_inf(sv, 1, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle, well before the next rising edge.
        #2 rst = 1'b1;
        #1 check_reset_vals("rst_async");
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        @(negedge clk);

        sv = '{-32'sd5, -32'sd2, -32'sd2, -32'sd9, -32'sd7, -32'sd100, -32'sd3, -32'sd50, -32'sd2000, -32'sd8};
        run_inf(sv, 0, 1'b0, 1'b0);
        foreach (sv[i]) sv[i] = 32'sd77;
        run_inf(sv, 2, 1'b0, 1'b0);

        foreach (sv[i]) sv[i] = 32'(i * 3);
        run_inf(sv, 2, 1'b1, 1'b0);

        foreach (sv[i]) sv[i] = 32'(100 - i);
        run_inf(sv, 20, 1'b0, 1'b1);
        foreach (sv[i]) sv[i] = 32'(i);
        run_inf(sv, 0, 1'b0, 1'b0);

        // Reset while the inference sits in WAIT.
        check("idle_before_wait_rst", 64'(ready), 64'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("in_wait", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("wait_rst_ready", 64'(ready), 64'd1);
        check("wait_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("no_done_after_wait_rst", 64'(seen), 64'd0);
        check("idle_after_wait_rst", 64'(ready), 64'd1);

        force dut.r_inf_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_inf_count;
        @(negedge clk);
        check("count_preload", 64'(inf_count), 64'hFFFF);
        model_cnt = 16'hFFFF;
        foreach (sv[i]) sv[i] = 32'($urandom);
        run_inf(sv, 1, 1'b0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 1) == 0) foreach (sv[i]) sv[i] = 32'($urandom);
            else foreach (sv[i]) sv[i] = 32'(int'($urandom_range(0, 6)) - 3);
            run_inf(sv, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
